dcache_line_fill_buffer: RTL and testbench

//  Responder side of the data-cache line-fill handshake. It accepts a miss request

---
 rtl/dcache_pkg.sv | 14 +
 rtl/lfb_wrap_counter.sv | 36 +++
 rtl/dcache_line_fill_buffer.sv | 86 ++++++++
 tb/tb_dcache_line_fill_buffer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared sizes, FSM state type and line-address helper for the data-cache line-fill buffer.
package dcache_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int LINE_W     = DATA_W * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} lfb_state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/lfb_wrap_counter.sv
// Beat counter for one line fill: the offset wraps modulo LINE_WORDS from a loadable start,
// and a flag marks the beat that carries the requested (critical) word.
module lfb_wrap_counter
  import dcache_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             adv,
  input  logic [OFF_W-1:0] start,
  input  logic [OFF_W-1:0] crit,
  output logic [OFF_W-1:0] cur_off,
  output logic             last_beat,
  output logic             hit_crit
);
  logic [OFF_W-1:0] start_q, crit_q, beat_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      start_q <= '0;
      crit_q  <= '0;
      beat_q  <= '0;
    end else if (load) begin
      start_q <= start;
      crit_q  <= crit;
      beat_q  <= '0;
    end else if (adv) begin
      beat_q  <= beat_q + 1'b1;
    end
  end

  // OFF_W-bit add gives the 7 -> 0 wrap for free
  assign cur_off   = start_q + beat_q;
  assign last_beat = &beat_q;
  assign hit_crit  = (cur_off == crit_q);
endmodule

// File: rtl/dcache_line_fill_buffer.sv
// Line-fill responder: fetches an 8-word line one word per beat and returns it to the cache.
// Define DCACHE_LFB_CWF_EN to enable critical-word-first ordering via RWordSelect.
module dcache_line_fill_buffer
  import dcache_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              LB_Enable,
  input  logic [ADDR_W-1:0] MissAddr,
  input  logic              RWordSelect,
  output logic              LB_Completed,
  output logic              LB_FirstWord,
  output logic [LINE_W-1:0] LB_LineData,
  output logic [ADDR_W-1:0] LB_LineAddr,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_RData,
  input  logic              Mem_Ack
);
  lfb_state_t state, nxt;
  logic [LINE_WORDS-1:0][DATA_W-1:0] line_q;
  logic [ADDR_W-1:0] laddr_q;
  logic              first_q;
  logic              accept, beat_done;
  logic [OFF_W-1:0]  start_off, cur_off;
  logic              last_beat, hit_crit;

`ifdef DCACHE_LFB_CWF_EN
  assign start_off = RWordSelect ? MissAddr[OFF_W-1:0] : '0;
`else
  logic unused_rws;
  assign unused_rws = RWordSelect;
  assign start_off  = '0;
`endif

  assign accept    = (state == IDLE) && LB_Enable;
  assign beat_done = (state == FETCH) && Mem_Ack;

  lfb_wrap_counter u_cnt (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (accept),
    .adv       (beat_done),
    .start     (start_off),
    .crit      (MissAddr[OFF_W-1:0]),
    .cur_off   (cur_off),
    .last_beat (last_beat),
    .hit_crit  (hit_crit)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= nxt;
  end

  // Enable dropping mid-fetch is deliberately not an abort
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (LB_Enable) nxt = FETCH;
      FETCH:   if (beat_done && last_beat) nxt = DONE;
      DONE:    if (!LB_Enable) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      line_q  <= '0;
      laddr_q <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= beat_done && hit_crit;
      if (accept)    laddr_q         <= line_addr(MissAddr);
      if (beat_done) line_q[cur_off] <= Mem_RData;
    end
  end

  // Req decodes straight from state so reset removes it without waiting for a clock
  assign Mem_Req      = (state == FETCH);
  assign Mem_Addr     = {laddr_q[ADDR_W-1:OFF_W], cur_off};
  assign LB_Completed = (state == DONE);
  assign LB_FirstWord = first_q;
  assign LB_LineData  = line_q;
  assign LB_LineAddr  = laddr_q;
endmodule

// File: tb/tb_dcache_line_fill_buffer.sv
// Directed bench for the line-fill buffer: memory responder, beat ordering and handshake checks.
module tb_dcache_line_fill_buffer;
  import dcache_pkg::*;

  logic              Clk = 1'b0;
  logic              Rst, LB_Enable, RWordSelect, Mem_Ack;
  logic [ADDR_W-1:0] MissAddr;
  logic [DATA_W-1:0] Mem_RData;
  logic              LB_Completed, LB_FirstWord, Mem_Req;
  logic [LINE_W-1:0] LB_LineData;
  logic [ADDR_W-1:0] LB_LineAddr, Mem_Addr;

  int errs = 0;
  int checks = 0;

  dcache_line_fill_buffer dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .LB_Enable    (LB_Enable),
    .MissAddr     (MissAddr),
    .RWordSelect  (RWordSelect),
    .LB_Completed (LB_Completed),
    .LB_FirstWord (LB_FirstWord),
    .LB_LineData  (LB_LineData),
    .LB_LineAddr  (LB_LineAddr),
    .Mem_Req      (Mem_Req),
    .Mem_Addr     (Mem_Addr),
    .Mem_RData    (Mem_RData),
    .Mem_Ack      (Mem_Ack)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] memw(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LINE_W-1:0] exp_line(input logic [ADDR_W-1:0] la);
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_WORDS; i++) r[i*DATA_W +: DATA_W] = memw(la + ADDR_W'(i));
    return r;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // One request: maxw = max wait cycles per beat, drop_at = beat at which Enable falls,
  // rst_at = beat at which Rst is asserted, hold = extra cycles Enable stays high in DONE
  task automatic fill(input logic [ADDR_W-1:0] addr, input bit rws, input int maxw,
                      input int drop_at, input int rst_at, input int hold);
    logic [ADDR_W-1:0] la, ea;
    logic [2:0] crit, start, o;
    int beats, cyc, wl, fw_n, fw_at;
    bit done;
    la   = {addr[ADDR_W-1:3], 3'b000};
    crit = addr[2:0];
`ifdef DCACHE_LFB_CWF_EN
    start = rws ? crit : 3'd0;
`else
    start = 3'd0;
`endif
    MissAddr = addr; RWordSelect = rws; LB_Enable = 1'b1;
    tick;
    MissAddr = ~addr;  // must have been captured at accept
    RWordSelect = ~rws;
    beats = 0; cyc = 1; fw_n = 0; fw_at = -1; done = 1'b0;
    wl = (maxw > 0) ? int'($urandom_range(0, maxw)) : 0;
    while (!done && cyc < 200) begin
      if (LB_FirstWord) begin
        fw_n++;
        fw_at = beats;
        chk("fw_lane", LB_LineData[int'(crit)*DATA_W +: DATA_W], memw(la + ADDR_W'(crit)));
      end
      if (beats == LINE_WORDS) begin
        chk("req_drop", Mem_Req, 1'b0);
        chk("completed", LB_Completed, 1'b1);
        done = 1'b1;
      end else if (beats == rst_at) begin
        Rst = 1'b1;
        #1;
        chk("rst_req", Mem_Req, 1'b0);
        chk("rst_outs", {LB_Completed, LB_FirstWord, LB_LineAddr, Mem_Addr}, '0);
        chk("rst_line", LB_LineData, '0);
        LB_Enable = 1'b0;
        tick;
        Rst = 1'b0;
        tick;
        return;
      end else begin
        o  = start + 3'(beats);
        ea = {la[ADDR_W-1:3], o};
        chk("req", Mem_Req, 1'b1);
        chk("mem_addr", Mem_Addr, ea);
        if (beats == drop_at) LB_Enable = 1'b0;
        if (wl == 0) begin
          Mem_Ack = 1'b1;
          Mem_RData = memw(ea);
          beats++;
          wl = (maxw > 0) ? int'($urandom_range(0, maxw)) : 0;
        end else begin
          Mem_Ack = 1'b0;
          wl--;
        end
        tick;
        cyc++;
        Mem_Ack = 1'b0;
        Mem_RData = '0;
      end
    end
    chk("fill_done", done, 1'b1);
    chk("fw_count", fw_n, 1);
    chk("fw_beat", fw_at, int'(3'(crit - start)) + 1);
    chk("line_data", LB_LineData, exp_line(la));
    chk("line_addr", LB_LineAddr, la);
    if (maxw == 0) chk("latency", cyc, 9);
    if (LB_Enable) begin
      for (int i = 0; i < hold; i++) begin
        tick;
        chk("hold_cmpl", LB_Completed, 1'b1);
        chk("hold_noreq", Mem_Req, 1'b0);
      end
      LB_Enable = 1'b0;
    end
    tick;
    chk("cmpl_low", LB_Completed, 1'b0);
    chk("line_stable", LB_LineData, exp_line(la));
  endtask

  initial begin
    Rst = 1'b0; LB_Enable = 1'b0; RWordSelect = 1'b0; Mem_Ack = 1'b0;
    MissAddr = '0; Mem_RData = '0;
    #2 Rst = 1'b1;
    #1;
    chk("reset_outs", {LB_Completed, LB_FirstWord, Mem_Req, LB_LineAddr, Mem_Addr}, '0);
    chk("reset_line", LB_LineData, '0);
    tick; tick;
    Rst = 1'b0;
    tick;

    fill(32'h4000_0002, 1'b0, 0, -1, 3, 0);   // reset mid-fetch
    fill(32'h1000_0005, 1'b0, 0, -1, -1, 0);  // clean restart, in-order fetch
    fill(32'h2000_0006, 1'b1, 0, -1, -1, 0);  // critical word first when enabled
    fill(32'h3000_0013, 1'b1, 5, -1, -1, 0);  // random wait states
    fill(32'h0ABC_DEF7, 1'b0, 5, -1, -1, 0);
    fill(32'h5000_0001, 1'b0, 0, -1, -1, 4);  // Enable held after completion
    fill(32'h6000_0004, 1'b0, 2, 2, -1, 0);   // Enable dropped at beat 2

    Mem_Ack = 1'b1; Mem_RData = 32'hDEAD_BEEF;  // stray ack while idle
    tick;
    Mem_Ack = 1'b0; Mem_RData = '0;
    tick;
    chk("stray_line", LB_LineData, exp_line(32'h6000_0000));
    chk("stray_outs", {Mem_Req, LB_Completed, LB_FirstWord}, 3'b000);
    chk("stray_laddr", LB_LineAddr, 32'h6000_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
